// File: rtl/lane_retire_stage_pkg.sv
// Shared constants for the two-lane retire stage: default widths, depth and lane count.
package lane_retire_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned NUM_LANES  = 2;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/lane_retire_stage_if.sv
// Per-lane upstream and consumer handshake bundle of the retire stage.
interface lane_retire_stage_if
    import lane_retire_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              in_valid_1;
    logic              in_valid_2;
    logic [DATA_W-1:0] in_data_1;
    logic [DATA_W-1:0] in_data_2;
    logic              in_flush_1;
    logic              in_flush_2;
    logic              out_stall_1;
    logic              out_stall_2;
    logic              out_valid_1;
    logic              out_valid_2;
    logic [DATA_W-1:0] out_data_1;
    logic [DATA_W-1:0] out_data_2;
    logic              in_stall_1;
    logic              in_stall_2;
    logic              out_flush_1;
    logic              out_flush_2;

    modport slave (
        input  in_valid_1, in_valid_2, in_data_1, in_data_2, in_flush_1, in_flush_2,
        input  in_stall_1, in_stall_2,
        output out_stall_1, out_stall_2, out_valid_1, out_valid_2, out_data_1, out_data_2,
        output out_flush_1, out_flush_2
    );

    modport master (
        output in_valid_1, in_valid_2, in_data_1, in_data_2, in_flush_1, in_flush_2,
        output in_stall_1, in_stall_2,
        input  out_stall_1, out_stall_2, out_valid_1, out_valid_2, out_data_1, out_data_2,
        input  out_flush_1, out_flush_2
    );

endinterface

// File: rtl/lane_skid_fifo.sv
// Single-lane result FIFO with flush, full-based stall and optional retire counter.
// Optional feature: RETIRE_CNT_EN adds o_retire_cnt.
module lane_skid_fifo
    import lane_retire_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
`ifdef RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_stall,
    output logic              o_flush
`ifdef RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_retire_cnt
`endif
);

    localparam int unsigned    PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [PTR_W:0]    w_count_d;
    logic              r_flush;
    logic              w_full;
    logic              w_empty;
    logic              w_enq;
    logic              w_deq;

    // Stall comes only from registered occupancy, never from this cycle's inputs.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_enq   = i_valid & ~w_full & ~i_flush;
    assign w_deq   = ~w_empty & ~i_stall;

    assign o_stall = w_full;
    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_flush = r_flush;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_enq, w_deq})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flush  <= 1'b0;
        end else begin
            r_flush <= i_flush;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_enq) r_mem[r_wr_ptr] <= i_data;
    end

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    // A dequeue coinciding with a flush still retired its entry, so it is counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_deq) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign o_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: rtl/lane_retire_stage.sv
// Two independent retire lanes, each a lane_skid_fifo; this level only wires ports.
// Optional feature: RETIRE_CNT_EN exposes retire_cnt_1/retire_cnt_2.
module lane_retire_stage
    import lane_retire_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
`ifdef RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_W  = CNT_W_DEF
`endif
) (
    input  logic                clk,
    input  logic                reset,
    lane_retire_stage_if.slave  bus
`ifdef RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]    retire_cnt_1,
    output logic [CNT_W-1:0]    retire_cnt_2
`endif
);

    lane_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
`ifdef RETIRE_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_lane_1 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (bus.in_valid_1),
        .i_data       (bus.in_data_1),
        .i_flush      (bus.in_flush_1),
        .o_stall      (bus.out_stall_1),
        .o_valid      (bus.out_valid_1),
        .o_data       (bus.out_data_1),
        .i_stall      (bus.in_stall_1),
        .o_flush      (bus.out_flush_1)
`ifdef RETIRE_CNT_EN
        ,
        .o_retire_cnt (retire_cnt_1)
`endif
    );

    lane_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
`ifdef RETIRE_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_lane_2 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (bus.in_valid_2),
        .i_data       (bus.in_data_2),
        .i_flush      (bus.in_flush_2),
        .o_stall      (bus.out_stall_2),
        .o_valid      (bus.out_valid_2),
        .o_data       (bus.out_data_2),
        .i_stall      (bus.in_stall_2),
        .o_flush      (bus.out_flush_2)
`ifdef RETIRE_CNT_EN
        ,
        .o_retire_cnt (retire_cnt_2)
`endif
    );

endmodule

// File: doc/lane_retire_stage.md
Name: lane_retire_stage

Overview:
- Downstream neighbour of the two-lane shared-resource stage. Consumes each lane's valid/data/flush output and returns a per-lane stall.
- Buffers results in one independent FIFO per lane and presents them to the retire/writeback consumer with its own per-lane stall.
- Lanes are fully independent; there is no cross-lane ordering.

Parameters:
- DATA_W, 32, width of each lane's data word.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- CNT_W, 16, width of each retire counter (used only with the optional feature).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid_1 / in_valid_2  input  1  upstream result valid, per lane.
- in_data_1 / in_data_2  input  DATA_W  upstream result data, per lane.
- in_flush_1 / in_flush_2  input  1  upstream flush, per lane.
- out_stall_1 / out_stall_2  output  1  backpressure to upstream; upstream holds data while high.
- out_valid_1 / out_valid_2  output  1  head entry valid toward the consumer.
- out_data_1 / out_data_2  output  DATA_W  head entry data.
- in_stall_1 / in_stall_2  input  1  consumer stall, per lane.
- out_flush_1 / out_flush_2  output  1  registered flush forwarded to the consumer.
- retire_cnt_1 / retire_cnt_2  output  CNT_W  retired-entry count; present only with RETIRE_CNT_EN.

Behaviour:
- Per lane N, state is:
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits, range 0..DEPTH.
  - storage array.
  - flush_q register.
- Reset (synchronous): pointers, count and flush_q cleared.
  - out_valid_N=0, out_stall_N=0, out_flush_N=0, out_data_N=0, retire_cnt_N=0.
  - Reset asserted mid-operation discards all buffered entries on that edge.
- out_stall_N = (count==DEPTH). Derived only from registered state; no combinational path from any input.
- enq_N = in_valid_N & !out_stall_N & !in_flush_N. Data is written at wr_ptr and wr_ptr increments.
- out_valid_N = (count!=0). out_data_N = storage[rd_ptr], first-word-fall-through from storage.
  - out_data_N is 0 when the lane is empty.
- deq_N = out_valid_N & !in_stall_N. rd_ptr increments.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - both: unchanged.
  - neither: unchanged.
- Latency: data accepted at edge k appears on out_valid_N/out_data_N after edge k (1 cycle) when the FIFO was empty.
- Full with deq in the same cycle: out_stall_N is still high that cycle, so there is no enqueue. Stall drops on the next cycle.
- Empty with in_valid_N: no bypass. The entry is visible only from the next cycle.
- Flush (in_flush_N=1 on an edge):
  - count, wr_ptr and rd_ptr are cleared.
  - That cycle's in_valid_N is dropped.
  - A deq in the same cycle still counts as retired.
  - out_flush_N=1 for exactly the following cycle (flush_q); consecutive flush cycles extend the pulse.
  - out_valid_N=0 in the cycle after the flush.
- Lanes never interact. A flush, stall or reset condition on lane 1 must not change lane 2's state, apart from the shared global reset.

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined:
  - retire_cnt_N ports exist.
  - Each increments by 1 on every deq_N and wraps modulo 2^CNT_W.
  - Cleared by reset only; flush does not clear it.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - DATA_W default.
  - DEPTH and CNT_W defaults.
  - Lane count constant (2).
  - Pointer-width constant derived as clog2(DEPTH).
- One sub-module, lane_skid_fifo, covers a single lane: FIFO, flush_q, stall/valid logic and optional counter. The top instantiates it twice and only wires ports.

Test Plan:
- Reset, then lane 1 enqueues 0xA1, 0xA2, 0xA3 on consecutive cycles with in_stall_1=0 -> out_data_1 shows 0xA1, 0xA2, 0xA3 one cycle after each accept; out_stall_1 never asserts.
- Hold in_stall_1=1 and drive 5 valids (0x10..0x14), DEPTH=4 -> out_stall_1 rises after the 4th accept and 0x14 is held. Release the stall -> 0x10..0x13 drain in order, then 0x14 is accepted the cycle after stall drops.
- Full FIFO, in_stall_1 drops for one cycle -> exactly one deq; out_stall_1 stays high that cycle and is low the next.
- Two entries buffered in lane 2 with in_flush_2=1 and in_valid_2=1 (data 0x55) -> next cycle out_valid_2=0 and out_flush_2=1 for one cycle; 0x55 is never output; lane 1 traffic is unaffected.
- Synchronous reset asserted with 3 entries in each lane -> next cycle all outputs are 0; a subsequent enqueue of 0x77 emerges as the first entry.
- With RETIRE_CNT_EN and CNT_W=4, retire 17 entries on lane 1 -> retire_cnt_1 reads 1 after wrap. A flush leaves the count unchanged; reset clears it to 0.
